serial_add_sub_seq: RTL

Bit-serial add/subtract sequencer. It takes a WIDTH-bit add or subtract request and runs it LSB-first through a single 1-bit add/sub cell with a registered carry, one bit per clock. It returns the full-width result, carry and signed overflow with a done pulse. It is used wherever a wide add/sub is needed but area matters more than latency, and it is the controller that owns the 1-bit add/sub datapath.

---
 rtl/serial_add_sub_seq.sv | 74 +++++++
 1 files changed

// File: rtl/serial_add_sub_seq.sv
// serial_add_sub_seq: bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock
// Ports: clk_in/rst_n_in clock and async active-low reset; start_in request strobe (IDLE only);
//        a_in/b_in operands and add_in (1 = A+B, 0 = A-B), sampled on the accepting edge;
//        busy_out high in RUN; done_out one-cycle completion pulse;
//        result_out/carry_out/overflow_out results, updated only on completion.
module serial_add_sub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             add_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             overflow_out
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
    logic [CW-1:0] cnt;
    logic c, sum, c_next, last;
    assign sum = a_sr[0] ^ b_sr[0] ^ c;
    assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign r_next = {sum, r_sr[WIDTH-1:1]};
    assign last = cnt == CW'(WIDTH - 1);
    assign busy_out = state == RUN;
    assign done_out = state == DONE;
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = start_in ? RUN : IDLE;
            RUN:  state_next = last ? DONE : RUN;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            cnt <= '0;
            c <= 1'b0;
            result_out <= '0;
            carry_out <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_in) begin
                a_sr <= a_in;
                // subtract as A + ~B + 1: invert B and preload the carry
                b_sr <= add_in ? b_in : ~b_in;
                c <= ~add_in;
                cnt <= '0;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_next;
                c <= c_next;
                cnt <= cnt + 1'b1;
                if (last) begin
                    result_out <= r_next;
                    carry_out <= c_next;
                    overflow_out <= c ^ c_next;
                end
            end
        end
    end
endmodule
